// File: rtl/axi4lite_arbiter_pkg.sv
// Shared AXI4-Lite bus configuration: widths and response codes.
package axi4lite_arbiter_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int AXI_RESP_WIDTH = 2;

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'd0;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'd2;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axi4lite_rr_picker.sv
// Two-way round-robin pick: on a tie, the requester that was not served last wins.
module axi4lite_rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Purely combinational so the caller decides when the pick is registered.
    always_comb begin
        valid  = |req;
        winner = (req[0] & req[1]) ? ~last : req[1];
    end

endmodule

// File: rtl/axi4lite_arbiter.sv
// Shares one AXI4-Lite master port between instruction fetch (S0) and
// load/store (S1). One whole transaction (AR+R or AW+W+B) per grant, with a
// registered round-robin grant and at least one idle cycle between grants.
module axi4lite_arbiter
    import axi4lite_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int MASK_WIDTH = AXI_MASK_WIDTH,
    parameter int RESP_WIDTH = AXI_RESP_WIDTH
) (
    input  logic                  iClock,
    input  logic                  iReset,

    output logic                  pM_ar_valid,
    input  logic                  pM_ar_ready,
    output logic [ADDR_WIDTH-1:0] pM_ar_bits_addr,
    input  logic                  pM_r_valid,
    output logic                  pM_r_ready,
    input  logic [DATA_WIDTH-1:0] pM_r_bits_data,
    input  logic [RESP_WIDTH-1:0] pM_r_bits_resp,
    output logic                  pM_aw_valid,
    input  logic                  pM_aw_ready,
    output logic [ADDR_WIDTH-1:0] pM_aw_bits_addr,
    output logic                  pM_w_valid,
    input  logic                  pM_w_ready,
    output logic [DATA_WIDTH-1:0] pM_w_bits_data,
    output logic [MASK_WIDTH-1:0] pM_w_bits_strb,
    input  logic                  pM_b_valid,
    output logic                  pM_b_ready,
    input  logic [RESP_WIDTH-1:0] pM_b_bits_resp,

    input  logic                  pS0_ar_valid,
    output logic                  pS0_ar_ready,
    input  logic [ADDR_WIDTH-1:0] pS0_ar_bits_addr,
    output logic                  pS0_r_valid,
    input  logic                  pS0_r_ready,
    output logic [DATA_WIDTH-1:0] pS0_r_bits_data,
    output logic [RESP_WIDTH-1:0] pS0_r_bits_resp,
    input  logic                  pS0_aw_valid,
    output logic                  pS0_aw_ready,
    input  logic [ADDR_WIDTH-1:0] pS0_aw_bits_addr,
    input  logic                  pS0_w_valid,
    output logic                  pS0_w_ready,
    input  logic [DATA_WIDTH-1:0] pS0_w_bits_data,
    input  logic [MASK_WIDTH-1:0] pS0_w_bits_strb,
    output logic                  pS0_b_valid,
    input  logic                  pS0_b_ready,
    output logic [RESP_WIDTH-1:0] pS0_b_bits_resp,

    input  logic                  pS1_ar_valid,
    output logic                  pS1_ar_ready,
    input  logic [ADDR_WIDTH-1:0] pS1_ar_bits_addr,
    output logic                  pS1_r_valid,
    input  logic                  pS1_r_ready,
    output logic [DATA_WIDTH-1:0] pS1_r_bits_data,
    output logic [RESP_WIDTH-1:0] pS1_r_bits_resp,
    input  logic                  pS1_aw_valid,
    output logic                  pS1_aw_ready,
    input  logic [ADDR_WIDTH-1:0] pS1_aw_bits_addr,
    input  logic                  pS1_w_valid,
    output logic                  pS1_w_ready,
    input  logic [DATA_WIDTH-1:0] pS1_w_bits_data,
    input  logic [MASK_WIDTH-1:0] pS1_w_bits_strb,
    output logic                  pS1_b_valid,
    input  logic                  pS1_b_ready,
    output logic [RESP_WIDTH-1:0] pS1_b_bits_resp,

    output logic [1:0]            oGrant,
    output logic                  oBusy
);

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RD   = 2'd1,
        STATE_WR   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   r_owner, r_last;
    logic   r_ar_done, r_aw_done, r_w_done;

    logic   pick_valid, pick_winner;
    logic   ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // Owner-side view of the requester signals.
    logic                  own_ar_valid, own_r_ready, own_aw_valid, own_w_valid, own_b_ready;
    logic [ADDR_WIDTH-1:0] own_ar_addr, own_aw_addr;
    logic [DATA_WIDTH-1:0] own_w_data;
    logic [MASK_WIDTH-1:0] own_w_strb;

    axi4lite_rr_picker u_picker (
        .req    ({pS1_ar_valid | pS1_aw_valid, pS0_ar_valid | pS0_aw_valid}),
        .last   (r_last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Select the current owner's request-side signals.
    always_comb begin
        own_ar_valid = r_owner ? pS1_ar_valid     : pS0_ar_valid;
        own_ar_addr  = r_owner ? pS1_ar_bits_addr : pS0_ar_bits_addr;
        own_r_ready  = r_owner ? pS1_r_ready      : pS0_r_ready;
        own_aw_valid = r_owner ? pS1_aw_valid     : pS0_aw_valid;
        own_aw_addr  = r_owner ? pS1_aw_bits_addr : pS0_aw_bits_addr;
        own_w_valid  = r_owner ? pS1_w_valid      : pS0_w_valid;
        own_w_data   = r_owner ? pS1_w_bits_data  : pS0_w_bits_data;
        own_w_strb   = r_owner ? pS1_w_bits_strb  : pS0_w_bits_strb;
        own_b_ready  = r_owner ? pS1_b_ready      : pS0_b_ready;
    end

    // Downstream handshakes; pM valids/readies are already state-qualified.
    always_comb begin
        ar_hs = pM_ar_valid & pM_ar_ready;
        r_hs  = pM_r_valid  & pM_r_ready;
        aw_hs = pM_aw_valid & pM_aw_ready;
        w_hs  = pM_w_valid  & pM_w_ready;
        b_hs  = pM_b_valid  & pM_b_ready;
    end

    // State register.
    always_ff @(posedge iClock) begin
        if (!iReset) state <= STATE_IDLE;
        else         state <= state_next;
    end

    // Next state: a write wins over a read within the picked requester;
    // the closing response returns to IDLE, even if B arrives early.
    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: begin
                if (pick_valid)
                    state_next = (pick_winner ? pS1_aw_valid : pS0_aw_valid) ? STATE_WR : STATE_RD;
            end
            STATE_RD: if (r_hs) state_next = STATE_IDLE;
            STATE_WR: if (b_hs) state_next = STATE_IDLE;
            default:  state_next = STATE_IDLE;
        endcase
    end

    // Owner, round-robin history and per-phase completion flags.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (pick_valid) r_owner <= pick_winner;
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                STATE_RD: begin
                    if (r_hs) begin
                        r_last    <= r_owner;
                        r_ar_done <= 1'b0;
                    end else if (ar_hs) begin
                        r_ar_done <= 1'b1;
                    end
                end
                STATE_WR: begin
                    if (b_hs) begin
                        r_last    <= r_owner;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) r_aw_done <= 1'b1;
                        if (w_hs)  r_w_done  <= 1'b1;
                    end
                end
                default: begin
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
            endcase
        end
    end

    // Route channels for the active transaction; everything else stays zero,
    // including while reset is held.
    always_comb begin
        pM_ar_valid     = 1'b0;
        pM_ar_bits_addr = '0;
        pM_r_ready      = 1'b0;
        pM_aw_valid     = 1'b0;
        pM_aw_bits_addr = '0;
        pM_w_valid      = 1'b0;
        pM_w_bits_data  = '0;
        pM_w_bits_strb  = '0;
        pM_b_ready      = 1'b0;

        pS0_ar_ready    = 1'b0;
        pS0_r_valid     = 1'b0;
        pS0_r_bits_data = '0;
        pS0_r_bits_resp = RESP_OKAY;
        pS0_aw_ready    = 1'b0;
        pS0_w_ready     = 1'b0;
        pS0_b_valid     = 1'b0;
        pS0_b_bits_resp = RESP_OKAY;

        pS1_ar_ready    = 1'b0;
        pS1_r_valid     = 1'b0;
        pS1_r_bits_data = '0;
        pS1_r_bits_resp = RESP_OKAY;
        pS1_aw_ready    = 1'b0;
        pS1_w_ready     = 1'b0;
        pS1_b_valid     = 1'b0;
        pS1_b_bits_resp = RESP_OKAY;

        oGrant = 2'b00;
        oBusy  = 1'b0;

        if (iReset) begin
            case (state)
                STATE_RD: begin
                    oBusy           = 1'b1;
                    oGrant          = r_owner ? 2'b10 : 2'b01;
                    pM_ar_valid     = own_ar_valid & ~r_ar_done;
                    pM_ar_bits_addr = own_ar_addr;
                    pM_r_ready      = own_r_ready;
                    if (r_owner) begin
                        pS1_ar_ready    = pM_ar_ready & ~r_ar_done;
                        pS1_r_valid     = pM_r_valid;
                        pS1_r_bits_data = pM_r_bits_data;
                        pS1_r_bits_resp = pM_r_bits_resp;
                    end else begin
                        pS0_ar_ready    = pM_ar_ready & ~r_ar_done;
                        pS0_r_valid     = pM_r_valid;
                        pS0_r_bits_data = pM_r_bits_data;
                        pS0_r_bits_resp = pM_r_bits_resp;
                    end
                end
                STATE_WR: begin
                    oBusy           = 1'b1;
                    oGrant          = r_owner ? 2'b10 : 2'b01;
                    pM_aw_valid     = own_aw_valid & ~r_aw_done;
                    pM_aw_bits_addr = own_aw_addr;
                    pM_w_valid      = own_w_valid & ~r_w_done;
                    pM_w_bits_data  = own_w_data;
                    pM_w_bits_strb  = own_w_strb;
                    pM_b_ready      = own_b_ready;
                    if (r_owner) begin
                        pS1_aw_ready    = pM_aw_ready & ~r_aw_done;
                        pS1_w_ready     = pM_w_ready & ~r_w_done;
                        pS1_b_valid     = pM_b_valid;
                        pS1_b_bits_resp = pM_b_bits_resp;
                    end else begin
                        pS0_aw_ready    = pM_aw_ready & ~r_aw_done;
                        pS0_w_ready     = pM_w_ready & ~r_w_done;
                        pS0_b_valid     = pM_b_valid;
                        pS0_b_bits_resp = pM_b_bits_resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter: reads, writes, round-robin order,
// out-of-order AW/W, write-over-read priority and mid-transaction reset.
module tb_axi4lite_arbiter;
    import axi4lite_arbiter_pkg::*;

    logic        iClock, iReset;
    logic        pM_ar_valid, pM_ar_ready, pM_r_valid, pM_r_ready;
    logic [31:0] pM_ar_bits_addr, pM_r_bits_data;
    logic [1:0]  pM_r_bits_resp;
    logic        pM_aw_valid, pM_aw_ready, pM_w_valid, pM_w_ready, pM_b_valid, pM_b_ready;
    logic [31:0] pM_aw_bits_addr, pM_w_bits_data;
    logic [3:0]  pM_w_bits_strb;
    logic [1:0]  pM_b_bits_resp;

    logic        pS0_ar_valid, pS0_ar_ready, pS0_r_valid, pS0_r_ready;
    logic [31:0] pS0_ar_bits_addr, pS0_r_bits_data;
    logic [1:0]  pS0_r_bits_resp;
    logic        pS0_aw_valid, pS0_aw_ready, pS0_w_valid, pS0_w_ready, pS0_b_valid, pS0_b_ready;
    logic [31:0] pS0_aw_bits_addr, pS0_w_bits_data;
    logic [3:0]  pS0_w_bits_strb;
    logic [1:0]  pS0_b_bits_resp;

    logic        pS1_ar_valid, pS1_ar_ready, pS1_r_valid, pS1_r_ready;
    logic [31:0] pS1_ar_bits_addr, pS1_r_bits_data;
    logic [1:0]  pS1_r_bits_resp;
    logic        pS1_aw_valid, pS1_aw_ready, pS1_w_valid, pS1_w_ready, pS1_b_valid, pS1_b_ready;
    logic [31:0] pS1_aw_bits_addr, pS1_w_bits_data;
    logic [3:0]  pS1_w_bits_strb;
    logic [1:0]  pS1_b_bits_resp;

    logic [1:0]  oGrant;
    logic        oBusy;

    int n_chk = 0;
    int n_err = 0;

    axi4lite_arbiter dut (
        .iClock(iClock), .iReset(iReset),
        .pM_ar_valid(pM_ar_valid), .pM_ar_ready(pM_ar_ready), .pM_ar_bits_addr(pM_ar_bits_addr),
        .pM_r_valid(pM_r_valid), .pM_r_ready(pM_r_ready), .pM_r_bits_data(pM_r_bits_data),
        .pM_r_bits_resp(pM_r_bits_resp),
        .pM_aw_valid(pM_aw_valid), .pM_aw_ready(pM_aw_ready), .pM_aw_bits_addr(pM_aw_bits_addr),
        .pM_w_valid(pM_w_valid), .pM_w_ready(pM_w_ready), .pM_w_bits_data(pM_w_bits_data),
        .pM_w_bits_strb(pM_w_bits_strb),
        .pM_b_valid(pM_b_valid), .pM_b_ready(pM_b_ready), .pM_b_bits_resp(pM_b_bits_resp),
        .pS0_ar_valid(pS0_ar_valid), .pS0_ar_ready(pS0_ar_ready), .pS0_ar_bits_addr(pS0_ar_bits_addr),
        .pS0_r_valid(pS0_r_valid), .pS0_r_ready(pS0_r_ready), .pS0_r_bits_data(pS0_r_bits_data),
        .pS0_r_bits_resp(pS0_r_bits_resp),
        .pS0_aw_valid(pS0_aw_valid), .pS0_aw_ready(pS0_aw_ready), .pS0_aw_bits_addr(pS0_aw_bits_addr),
        .pS0_w_valid(pS0_w_valid), .pS0_w_ready(pS0_w_ready), .pS0_w_bits_data(pS0_w_bits_data),
        .pS0_w_bits_strb(pS0_w_bits_strb),
        .pS0_b_valid(pS0_b_valid), .pS0_b_ready(pS0_b_ready), .pS0_b_bits_resp(pS0_b_bits_resp),
        .pS1_ar_valid(pS1_ar_valid), .pS1_ar_ready(pS1_ar_ready), .pS1_ar_bits_addr(pS1_ar_bits_addr),
        .pS1_r_valid(pS1_r_valid), .pS1_r_ready(pS1_r_ready), .pS1_r_bits_data(pS1_r_bits_data),
        .pS1_r_bits_resp(pS1_r_bits_resp),
        .pS1_aw_valid(pS1_aw_valid), .pS1_aw_ready(pS1_aw_ready), .pS1_aw_bits_addr(pS1_aw_bits_addr),
        .pS1_w_valid(pS1_w_valid), .pS1_w_ready(pS1_w_ready), .pS1_w_bits_data(pS1_w_bits_data),
        .pS1_w_bits_strb(pS1_w_bits_strb),
        .pS1_b_valid(pS1_b_valid), .pS1_b_ready(pS1_b_ready), .pS1_b_bits_resp(pS1_b_bits_resp),
        .oGrant(oGrant), .oBusy(oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick;
        @(posedge iClock);
        #1;
    endtask

    initial begin
        iReset = 1'b0;
        {pM_ar_ready, pM_r_valid, pM_aw_ready, pM_w_ready, pM_b_valid} = '0;
        pM_r_bits_data = '0; pM_r_bits_resp = '0; pM_b_bits_resp = '0;
        {pS0_ar_valid, pS0_r_ready, pS0_aw_valid, pS0_w_valid, pS0_b_ready} = '0;
        pS0_ar_bits_addr = '0; pS0_aw_bits_addr = '0; pS0_w_bits_data = '0; pS0_w_bits_strb = '0;
        {pS1_ar_valid, pS1_r_ready, pS1_aw_valid, pS1_w_valid, pS1_b_ready} = '0;
        pS1_ar_bits_addr = '0; pS1_aw_bits_addr = '0; pS1_w_bits_data = '0; pS1_w_bits_strb = '0;

        // Reset: outputs zero even with a request present.
        tick; tick;
        pS0_ar_valid = 1'b1; pS0_ar_bits_addr = 32'h8000_0000;
        #1;
        chk("rst_grant", oGrant, 2'b00);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_ar_valid", pM_ar_valid, 1'b0);
        chk("rst_addr", pM_ar_bits_addr, 32'h0);
        pS0_ar_valid = 1'b0;
        tick;
        iReset = 1'b1;

        // 1. S0 read only.
        tick;
        pS0_ar_valid = 1'b1; pS0_ar_bits_addr = 32'h8000_0000; pS0_r_ready = 1'b1;
        #1;
        chk("t1_idle_ar_valid", pM_ar_valid, 1'b0);
        chk("t1_idle_grant", oGrant, 2'b00);
        tick;
        chk("t1_ar_valid", pM_ar_valid, 1'b1);
        chk("t1_ar_addr", pM_ar_bits_addr, 32'h8000_0000);
        chk("t1_grant", oGrant, 2'b01);
        chk("t1_busy", oBusy, 1'b1);
        pM_ar_ready = 1'b1;
        #1;
        chk("t1_s0_ar_ready", pS0_ar_ready, 1'b1);
        chk("t1_s1_ar_ready", pS1_ar_ready, 1'b0);
        tick;
        pM_ar_ready = 1'b0;
        #1;
        chk("t1_ar_masked", pM_ar_valid, 1'b0);
        pS0_ar_valid = 1'b0;
        pM_r_valid = 1'b1; pM_r_bits_data = 32'hDEAD_BEEF; pM_r_bits_resp = RESP_OKAY;
        #1;
        chk("t1_s0_r_valid", pS0_r_valid, 1'b1);
        chk("t1_s0_r_data", pS0_r_bits_data, 32'hDEAD_BEEF);
        chk("t1_s1_r_valid", pS1_r_valid, 1'b0);
        chk("t1_s1_r_data", pS1_r_bits_data, 32'h0);
        chk("t1_m_r_ready", pM_r_ready, 1'b1);
        chk("t1_m_b_ready", pM_b_ready, 1'b0);
        tick;
        pM_r_valid = 1'b0;
        #1;
        chk("t1_back_idle", oBusy, 1'b0);

        // 2. Simultaneous requests right after reset: S0 (read) first.
        iReset = 1'b0;
        tick;
        iReset = 1'b1;
        pS0_ar_valid = 1'b1; pS0_ar_bits_addr = 32'h8000_0010;
        pS1_aw_valid = 1'b1; pS1_aw_bits_addr = 32'h8000_0100;
        pS1_w_valid = 1'b1; pS1_w_bits_data = 32'h1234_5678; pS1_w_bits_strb = 4'hF;
        pS1_b_ready = 1'b1;
        tick;
        chk("t2_grant0", oGrant, 2'b01);
        chk("t2_ar_addr", pM_ar_bits_addr, 32'h8000_0010);
        chk("t2_aw_blocked", pM_aw_valid, 1'b0);
        pM_ar_ready = 1'b1;
        #1;
        chk("t2_s1_aw_ready", pS1_aw_ready, 1'b0);
        tick;
        pM_ar_ready = 1'b0; pS0_ar_valid = 1'b0;
        pM_r_valid = 1'b1; pM_r_bits_data = 32'h0000_A5A5;
        #1;
        chk("t2_s0_r_data", pS0_r_bits_data, 32'h0000_A5A5);
        tick;
        pM_r_valid = 1'b0;
        #1;
        chk("t2_gap", oGrant, 2'b00);
        tick;
        chk("t2_grant1", oGrant, 2'b10);
        chk("t2_aw_valid", pM_aw_valid, 1'b1);
        chk("t2_aw_addr", pM_aw_bits_addr, 32'h8000_0100);
        chk("t2_w_data", pM_w_bits_data, 32'h1234_5678);
        chk("t2_w_strb", pM_w_bits_strb, 4'hF);
        pM_aw_ready = 1'b1; pM_w_ready = 1'b1;
        #1;
        chk("t2_s1_aw_ready", pS1_aw_ready, 1'b1);
        chk("t2_s1_w_ready", pS1_w_ready, 1'b1);
        chk("t2_s0_aw_ready", pS0_aw_ready, 1'b0);
        tick;
        pM_aw_ready = 1'b0; pM_w_ready = 1'b0;
        pS1_aw_valid = 1'b0; pS1_w_valid = 1'b0;
        pM_b_valid = 1'b1; pM_b_bits_resp = RESP_OKAY;
        #1;
        chk("t2_s1_b_valid", pS1_b_valid, 1'b1);
        chk("t2_m_b_ready", pM_b_ready, 1'b1);
        chk("t2_m_r_ready", pM_r_ready, 1'b0);
        tick;
        pM_b_valid = 1'b0;

        // 3. Both hold reads: owners alternate 0,1,0,1 with one idle gap each.
        pS0_ar_valid = 1'b1; pS0_ar_bits_addr = 32'h0000_0100;
        pS1_ar_valid = 1'b1; pS1_ar_bits_addr = 32'h0000_0200; pS1_r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_gap", oGrant, 2'b00);
            tick;
            chk("t3_grant", oGrant, (i % 2) ? 2'b10 : 2'b01);
            chk("t3_addr", pM_ar_bits_addr, (i % 2) ? 32'h0000_0200 : 32'h0000_0100);
            pM_ar_ready = 1'b1;
            tick;
            pM_ar_ready = 1'b0;
            pM_r_valid = 1'b1; pM_r_bits_data = 32'(i + 16);
            #1;
            chk("t3_r_data", (i % 2) ? pS1_r_bits_data : pS0_r_bits_data, 32'(i + 16));
            tick;
            pM_r_valid = 1'b0;
        end
        pS0_ar_valid = 1'b0; pS1_ar_valid = 1'b0;
        tick;

        // 4. W handshakes before AW (AW ready held off 3 cycles), SLVERR returned.
        pS0_aw_valid = 1'b1; pS0_aw_bits_addr = 32'h8000_0200;
        pS0_w_valid = 1'b1; pS0_w_bits_data = 32'hCAFE_F00D; pS0_w_bits_strb = 4'h3;
        pS0_b_ready = 1'b1;
        tick;
        chk("t4_grant", oGrant, 2'b01);
        pM_w_ready = 1'b1;
        #1;
        chk("t4_w_valid", pM_w_valid, 1'b1);
        chk("t4_s0_w_ready", pS0_w_ready, 1'b1);
        chk("t4_s0_aw_ready", pS0_aw_ready, 1'b0);
        tick;
        chk("t4_w_masked", pM_w_valid, 1'b0);
        chk("t4_w_ready_masked", pS0_w_ready, 1'b0);
        chk("t4_aw_pending", pM_aw_valid, 1'b1);
        pS0_w_valid = 1'b0; pM_w_ready = 1'b0;
        tick;
        tick;
        pM_aw_ready = 1'b1;
        #1;
        chk("t4_s0_aw_ready_late", pS0_aw_ready, 1'b1);
        tick;
        pM_aw_ready = 1'b0; pS0_aw_valid = 1'b0;
        pM_b_valid = 1'b1; pM_b_bits_resp = RESP_SLVERR;
        #1;
        chk("t4_b_valid", pS0_b_valid, 1'b1);
        chk("t4_b_resp", pS0_b_bits_resp, 2'd2);
        chk("t4_s1_b_valid", pS1_b_valid, 1'b0);
        tick;
        pM_b_valid = 1'b0;
        #1;
        chk("t4_idle", oBusy, 1'b0);

        // 5. S1 raises AW and AR together: write first, read in a later grant.
        pS1_aw_valid = 1'b1; pS1_aw_bits_addr = 32'h8000_0300;
        pS1_w_valid = 1'b1; pS1_w_bits_data = 32'h5555_AAAA; pS1_w_bits_strb = 4'hC;
        pS1_ar_valid = 1'b1; pS1_ar_bits_addr = 32'h8000_0400;
        pS1_r_ready = 1'b0;
        tick;
        chk("t5_grant", oGrant, 2'b10);
        chk("t5_aw_valid", pM_aw_valid, 1'b1);
        chk("t5_ar_blocked", pM_ar_valid, 1'b0);
        pM_aw_ready = 1'b1; pM_w_ready = 1'b1;
        tick;
        pM_aw_ready = 1'b0; pM_w_ready = 1'b0;
        pS1_aw_valid = 1'b0; pS1_w_valid = 1'b0;
        pM_b_valid = 1'b1; pM_b_bits_resp = RESP_DECERR;
        #1;
        chk("t5_b_resp", pS1_b_bits_resp, 2'd3);
        tick;
        pM_b_valid = 1'b0;
        #1;
        chk("t5_gap", oBusy, 1'b0);
        tick;
        chk("t5_rd_grant", oGrant, 2'b10);
        chk("t5_rd_addr", pM_ar_bits_addr, 32'h8000_0400);

        // 6. Reset mid-read with R pending, then a fresh S1 request.
        pM_r_valid = 1'b1; pM_r_bits_data = 32'h0000_0077;
        #1;
        chk("t6_r_pending", pS1_r_valid, 1'b1);
        chk("t6_m_r_ready", pM_r_ready, 1'b0);
        iReset = 1'b0;
        tick;
        chk("t6_rst_grant", oGrant, 2'b00);
        chk("t6_rst_busy", oBusy, 1'b0);
        chk("t6_rst_r_valid", pS1_r_valid, 1'b0);
        chk("t6_rst_ar_valid", pM_ar_valid, 1'b0);
        iReset = 1'b1; pM_r_valid = 1'b0;
        #1;
        chk("t6_idle_grant", oGrant, 2'b00);
        tick;
        chk("t6_regrant", oGrant, 2'b10);
        chk("t6_ar_addr", pM_ar_bits_addr, 32'h8000_0400);
        chk("t6_ar_valid", pM_ar_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_arbiter.md
Name: axi4lite_arbiter

Overview:
- Shares one AXI4-Lite master port between two requesters: requester 0 is instruction fetch and requester 1 is load/store.
- Sits between the two per-unit AXI4-Lite master blocks and the single downstream bus toward the crossbar/SRAM.
- Grants the bus for one complete transaction at a time: one read (AR+R) or one write (AW+W+B).
- Round-robin between requesters; grant is registered, so there is no combinational path from request to grant.

Parameters:
ADDR_WIDTH, 32, address width (shared define)
DATA_WIDTH, 32, data width (shared define)
MASK_WIDTH, 4, write strobe width, DATA_WIDTH/8
RESP_WIDTH, 2, response width

Ports:
iClock  in  1  clock
iReset  in  1  reset, synchronous, active-low
pM_ar_valid out 1; pM_ar_ready in 1; pM_ar_bits_addr out ADDR_WIDTH  downstream read address
pM_r_valid in 1; pM_r_ready out 1; pM_r_bits_data in DATA_WIDTH; pM_r_bits_resp in RESP_WIDTH  downstream read data
pM_aw_valid out 1; pM_aw_ready in 1; pM_aw_bits_addr out ADDR_WIDTH  downstream write address
pM_w_valid out 1; pM_w_ready in 1; pM_w_bits_data out DATA_WIDTH; pM_w_bits_strb out MASK_WIDTH  downstream write data
pM_b_valid in 1; pM_b_ready out 1; pM_b_bits_resp in RESP_WIDTH  downstream write response
pS0_* / pS1_*: the same 17 signal names and widths as pM_*, with every direction inverted (requester-facing)
oGrant  out 2  one-hot current owner, 00 when idle
oBusy  out 1  high in RD or WR state

Behaviour:
- State machine, registered, 2 bits:
  - STATE_IDLE=0
  - STATE_RD=1
  - STATE_WR=2
  - code 3 is illegal and goes to IDLE.
- Registers:
  - r_owner (1 bit)
  - r_last (last served requester; resets to 1 so S0 wins first)
  - r_ar_done, r_aw_done, r_w_done (address/data phase already handshaked).
- Reset (iReset=0): state IDLE, r_owner=0, r_last=1, all done flags 0. All outputs 0: every valid, ready, addr, data, strb, resp, oGrant, oBusy.
- IDLE:
  - reqN = pSN_ar_valid | pSN_aw_valid.
  - Neither requesting: stay in IDLE.
  - One requesting: that one wins.
  - Both requesting: the winner is the requester != r_last.
  - Within the winner, aw_valid takes precedence over ar_valid, i.e. write goes to WR, otherwise RD.
  - r_owner is loaded on the transition.
  - In IDLE all pM valids are 0 and all pS readies and valids are 0.
- Latency: a request seen in cycle N is driven on pM in cycle N+1. A requester holding valid across the gap is AXI-legal.
- RD:
  - pM_ar_valid = owner ar_valid & !r_ar_done; pM_ar_bits_addr = owner addr.
  - owner ar_ready = pM_ar_ready & !r_ar_done.
  - r_ar_done is set on the AR handshake.
  - pM_r_* routed to the owner; pM_r_ready = owner r_ready.
  - On the R handshake: next state IDLE, r_last<=r_owner, done flags cleared.
- WR:
  - AW forwarded, masked by r_aw_done.
  - W forwarded, masked by r_w_done.
  - AW and W are independent; either order or the same cycle is legal.
  - B routed to the owner; pM_b_ready = owner b_ready.
  - On the B handshake: next state IDLE, r_last<=r_owner, flags cleared.
  - A B arriving before both AW and W are done is a downstream protocol error. It is still accepted, and the arbiter returns to IDLE.
- Non-owner during RD/WR: all its readies 0, r_valid and b_valid 0, data/resp outputs 0. Its request stays pending and is arbitrated in the next IDLE.
- Response codes pass through unmodified (SLVERR/DECERR are not interpreted).
- Back-to-back: the minimum gap is one IDLE cycle between transactions. A requester cannot hold the bus for two consecutive transactions while the other is requesting.
- Simultaneous R and B: only the channel matching the current state is routed. The other pM ready is 0.
- Reset mid-transaction: immediate return to IDLE with outputs zeroed. The downstream is reset by the same iReset, so no orphan tracking is needed.
- oGrant = state!=IDLE ? (r_owner ? 2'b10 : 2'b01) : 2'b00.
- oBusy = state!=IDLE.

Decomposition:
- Shared Config.v: ADDR_WIDTH, DATA_WIDTH, MASK_WIDTH, RESP_WIDTH, and the RESP_OKAY/SLVERR/DECERR codes.
- Arbiter state encodings are module-local parameters.
- One sub-module: axi4lite_rr_picker.
  - Inputs: two request bits, last-served bit.
  - Outputs: valid, winner index.
  - Combinational, reusable when a DMA requester is added later.

Test Plan:
1. S0 read only: S0 ar_valid addr 0x8000_0000, slave returns data 0xDEADBEEF, resp 0 → pM_ar_valid rises 1 cycle later, S0 sees r_data 0xDEADBEEF; S1 signals stay 0; back to IDLE after the R handshake.
2. Both request in the same cycle after reset: S0 read 0x8000_0010, S1 write 0x8000_0100 data 0x1234_5678 strb 0xF → S0 is served first (r_last=1); S1's AW+W are forwarded in the following grant with strb 0xF.
3. Round-robin: both hold requests continuously for 4 transactions → owner sequence 0,1,0,1; each transaction separated by exactly one IDLE cycle.
4. Write with W accepted before AW (pM_w_ready=1, pM_aw_ready delayed 3 cycles) → w_valid masked after the W handshake, AW completes, B resp 2 (SLVERR) delivered to the owner unchanged.
5. S1 issues aw_valid and ar_valid together → WR is taken first; the read is served in a later grant.
6. iReset asserted during RD with pM_r_valid pending → all outputs 0 the next cycle, state IDLE; a fresh S1 request is then granted normally.
